alu_arbiter: RTL and testbench

Shares one combinational ALU between two requesters, for example the integer pipe and the branch/address unit. Each requester presents an ALU op with a valid/ready handshake. The arbiter picks one request per cycle with round-robin priority, registers it into an issue stage that drives the ALU, and registers the ALU output into a response stage. It sits between the requesters and a single ALU instance and is the only driver of that ALU's inputs.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_rr_arb2.sv | 32 +++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: operation encodings, widths and the requester id type.
package alu_pkg;

  localparam int CTR_W  = 3;
  localparam int DATA_W = 32;

  typedef logic [CTR_W-1:0]  alu_ctr_t;
  typedef logic [DATA_W-1:0] alu_data_t;
  typedef logic              req_id_t;

  localparam alu_ctr_t ALU_ADD = 3'b000;
  localparam alu_ctr_t ALU_SUB = 3'b001;
  localparam alu_ctr_t ALU_OR  = 3'b010;
  localparam alu_ctr_t ALU_LUI = 3'b011;

  // Any encoding with the top bit set is not an ALU operation.
  function automatic logic is_illegal(alu_ctr_t ctr);
    return ctr[CTR_W-1];
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; remembers the last winner so ties alternate.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  req_id_t lastGrant_q, lastGrant_d;

  // On a tie the requester that did not win last time goes first; flush blocks every grant.
  always_comb begin
    grant_o     = 2'b00;
    lastGrant_d = lastGrant_q;
    if (!flush_i) begin
      grant_o[0] = valid_i[0] && (!valid_i[1] || (lastGrant_q == 1'b1));
      grant_o[1] = valid_i[1] && (!valid_i[0] || (lastGrant_q == 1'b0));
    end
    if (grant_o[0]) lastGrant_d = 1'b0;
    if (grant_o[1]) lastGrant_d = 1'b1;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lastGrant_q <= 1'b1;
    else        lastGrant_q <= lastGrant_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters through an
// issue stage (drives the ALU) and a response stage (captures its output).
module alu_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [2:0]       req_ctr_0,
  input  logic [2:0]       req_ctr_1,
  input  logic [31:0]      req_op1_0,
  input  logic [31:0]      req_op1_1,
  input  logic [31:0]      req_op2_0,
  input  logic [31:0]      req_op2_1,
  output logic [2:0]       alu_ctr,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  output logic [31:0]      resp_result,
  output logic             resp_zero,
  output logic             err_illegal
);

  logic [1:0] grant;
  logic       anyGrant;
  req_id_t    selId;
  alu_ctr_t   selCtr;
  alu_data_t  selOp1, selOp2;

  logic      s1V_q, s1V_d;
  req_id_t   s1Id_q, s1Id_d;
  alu_ctr_t  s1Ctr_q, s1Ctr_d;
  alu_data_t s1Op1_q, s1Op1_d, s1Op2_q, s1Op2_d;

  logic      s2V_q, s2V_d;
  req_id_t   s2Id_q;
  alu_data_t s2Result_q;
  logic      s2Zero_q;

  logic errIllegal_q, errIllegal_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .valid_i ({req_valid_1, req_valid_0}),
    .grant_o (grant)
  );

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  assign anyGrant    = |grant;
  assign selId       = req_id_t'(grant[1]);
  assign selCtr      = grant[1] ? req_ctr_1 : req_ctr_0;
  assign selOp1      = grant[1] ? req_op1_1 : req_op1_0;
  assign selOp2      = grant[1] ? req_op2_1 : req_op2_0;

  // Issue stage loads only on a grant; its payload is ignored while s1V is low.
  always_comb begin
    s1V_d        = anyGrant;
    s1Id_d       = s1Id_q;
    s1Ctr_d      = s1Ctr_q;
    s1Op1_d      = s1Op1_q;
    s1Op2_d      = s1Op2_q;
    errIllegal_d = errIllegal_q;
    if (anyGrant) begin
      s1Id_d  = selId;
      s1Ctr_d = selCtr;
      s1Op1_d = selOp1;
      s1Op2_d = selOp2;
      if (is_illegal(selCtr)) errIllegal_d = 1'b1;
    end
  end

  assign s2V_d = s1V_q && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1V_q        <= 1'b0;
      s1Id_q       <= 1'b0;
      s1Ctr_q      <= ALU_ADD;
      s1Op1_q      <= '0;
      s1Op2_q      <= '0;
      s2V_q        <= 1'b0;
      s2Id_q       <= 1'b0;
      s2Result_q   <= '0;
      s2Zero_q     <= 1'b0;
      errIllegal_q <= 1'b0;
    end else begin
      s1V_q        <= s1V_d;
      s1Id_q       <= s1Id_d;
      s1Ctr_q      <= s1Ctr_d;
      s1Op1_q      <= s1Op1_d;
      s1Op2_q      <= s1Op2_d;
      s2V_q        <= s2V_d;
      s2Id_q       <= s1Id_q;
      s2Result_q   <= alu_result;
      s2Zero_q     <= alu_zero;
      errIllegal_q <= errIllegal_d;
    end
  end

  // An idle or illegal issue slot presents add 0+0, so an illegal op answers result 0, zero 1.
  always_comb begin
    alu_ctr = ALU_ADD;
    alu_op1 = '0;
    alu_op2 = '0;
    if (s1V_q && !is_illegal(s1Ctr_q)) begin
      alu_ctr = s1Ctr_q;
      alu_op1 = s1Op1_q;
      alu_op2 = s1Op2_q;
    end
  end

  assign resp_valid_0 = s2V_q && (s2Id_q == 1'b0);
  assign resp_valid_1 = s2V_q && (s2Id_q == 1'b1);
  assign resp_result  = s2Result_q;
  assign resp_zero    = s2Zero_q;
  assign err_illegal  = errIllegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU sits beside the DUT on its ALU ports.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [2:0]  req_ctr_0, req_ctr_1;
  logic [31:0] req_op1_0, req_op1_1, req_op2_0, req_op2_1;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_op1, alu_op2;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        resp_valid_0, resp_valid_1;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        err_illegal;

  int errors = 0;
  int checks = 0;

  alu_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid_0  (req_valid_0),
    .req_valid_1  (req_valid_1),
    .req_ready_0  (req_ready_0),
    .req_ready_1  (req_ready_1),
    .req_ctr_0    (req_ctr_0),
    .req_ctr_1    (req_ctr_1),
    .req_op1_0    (req_op1_0),
    .req_op1_1    (req_op1_1),
    .req_op2_0    (req_op2_0),
    .req_op2_1    (req_op2_1),
    .alu_ctr      (alu_ctr),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .resp_valid_0 (resp_valid_0),
    .resp_valid_1 (resp_valid_1),
    .resp_result  (resp_result),
    .resp_zero    (resp_zero),
    .err_illegal  (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (alu_ctr)
      3'b000:  alu_result = alu_op1 + alu_op2;
      3'b001:  alu_result = alu_op1 - alu_op2;
      3'b010:  alu_result = alu_op1 | alu_op2;
      3'b011:  alu_result = alu_op2 << 16;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq0(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req_valid_0 = v; req_ctr_0 = c; req_op1_0 = a; req_op2_0 = b;
  endtask

  task automatic setReq1(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    req_valid_1 = v; req_ctr_1 = c; req_op1_1 = a; req_op2_1 = b;
  endtask

  task automatic idleInputs();
    setReq0(1'b0, 3'b000, 32'h0, 32'h0);
    setReq1(1'b0, 3'b000, 32'h0, 32'h0);
    flush = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b0;
    stepCycle();
    stepCycle();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b0;
    #1;
    checks++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got=%b%b want=00", req_ready_1, req_ready_0); end
    checks++; if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got=%b%b want=00", resp_valid_1, resp_valid_0); end
    checks++; if (resp_result !== 32'h0 || resp_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp got=%h/%b want=0/0", resp_result, resp_zero); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b want=0", err_illegal); end
    checks++; if (alu_ctr !== 3'b000 || alu_op1 !== 32'h0 || alu_op2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu got=%b/%h/%h want=000/0/0", alu_ctr, alu_op1, alu_op2); end
    stepCycle();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_single();
    setReq0(1'b1, 3'b000, 32'd5, 32'd7);
    #1;
    checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin errors++; $display("[TB] FAIL single_ready got=%b%b want=01", req_ready_1, req_ready_0); end
    stepCycle();
    idleInputs();
    #1;
    checks++; if (alu_ctr !== 3'b000 || alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin errors++; $display("[TB] FAIL single_alu_drive got=%b/%h/%h want=000/5/7", alu_ctr, alu_op1, alu_op2); end
    checks++; if (resp_valid_0 !== 1'b0) begin errors++; $display("[TB] FAIL single_early_resp got=%b want=0", resp_valid_0); end
    stepCycle();
    checks++; if (resp_valid_0 !== 1'b1 || resp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL single_resp_valid got=%b%b want=01", resp_valid_1, resp_valid_0); end
    checks++; if (resp_result !== 32'd12 || resp_zero !== 1'b0) begin errors++; $display("[TB] FAIL single_resp_data got=%h/%b want=0000000c/0", resp_result, resp_zero); end
    stepCycle();
    checks++; if (resp_valid_0 !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_width got=%b want=0", resp_valid_0); end
  endtask

  task automatic test_contention();
    logic expId;
    doReset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        setReq0(1'b1, 3'b001, 32'd3, 32'd3);
        setReq1(1'b1, 3'b011, 32'hDEAD, 32'h1234);
      end else begin
        idleInputs();
      end
      #1;
      if (i < 4) begin
        expId = (i % 2 == 1);
        checks++;
        if (req_ready_0 !== !expId || req_ready_1 !== expId) begin
          errors++; $display("[TB] FAIL contention_grant[%0d] got=%b%b want=%b%b", i, req_ready_1, req_ready_0, expId, !expId);
        end
      end
      if (i >= 2) begin
        expId = ((i - 2) % 2 == 1);
        checks++;
        if (resp_valid_0 !== !expId || resp_valid_1 !== expId) begin
          errors++; $display("[TB] FAIL contention_resp_valid[%0d] got=%b%b want=%b%b", i, resp_valid_1, resp_valid_0, expId, !expId);
        end
        checks++;
        if (expId ? (resp_result !== 32'h12340000 || resp_zero !== 1'b0)
                  : (resp_result !== 32'h0 || resp_zero !== 1'b1)) begin
          errors++; $display("[TB] FAIL contention_resp_data[%0d] got=%h/%b want=%h/%b", i, resp_result, resp_zero,
                             expId ? 32'h12340000 : 32'h0, !expId);
        end
      end
      stepCycle();
    end
  endtask

  task automatic test_back_to_back();
    idleInputs();
    setReq1(1'b1, 3'b010, 32'hF0, 32'h0F);
    #1;
    checks++; if (req_ready_1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_a got=%b want=1", req_ready_1); end
    stepCycle();
    setReq1(1'b1, 3'b000, 32'hFFFFFFFF, 32'h1);
    #1;
    checks++; if (req_ready_1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_b got=%b want=1", req_ready_1); end
    stepCycle();
    idleInputs();
    #1;
    checks++; if (resp_valid_1 !== 1'b1 || resp_result !== 32'hFF || resp_zero !== 1'b0) begin errors++; $display("[TB] FAIL b2b_resp_a got=%b/%h/%b want=1/000000ff/0", resp_valid_1, resp_result, resp_zero); end
    stepCycle();
    checks++; if (resp_valid_1 !== 1'b1 || resp_result !== 32'h0 || resp_zero !== 1'b1) begin errors++; $display("[TB] FAIL b2b_resp_wrap got=%b/%h/%b want=1/00000000/1", resp_valid_1, resp_result, resp_zero); end
    stepCycle();
    checks++; if (resp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tail got=%b want=0", resp_valid_1); end
  endtask

  task automatic test_illegal();
    idleInputs();
    setReq0(1'b1, 3'b101, 32'd9, 32'd9);
    #1;
    checks++; if (req_ready_0 !== 1'b1 || err_illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_accept got=%b/%b want=1/0", req_ready_0, err_illegal); end
    stepCycle();
    idleInputs();
    #1;
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err_rise got=%b want=1", err_illegal); end
    checks++; if (alu_ctr !== 3'b000 || alu_op1 !== 32'h0 || alu_op2 !== 32'h0) begin errors++; $display("[TB] FAIL illegal_alu_drive got=%b/%h/%h want=000/0/0", alu_ctr, alu_op1, alu_op2); end
    stepCycle();
    checks++; if (resp_valid_0 !== 1'b1 || resp_result !== 32'h0 || resp_zero !== 1'b1) begin errors++; $display("[TB] FAIL illegal_resp got=%b/%h/%b want=1/00000000/1", resp_valid_0, resp_result, resp_zero); end
    setReq0(1'b1, 3'b000, 32'd1, 32'd1);
    stepCycle();
    idleInputs();
    stepCycle();
    stepCycle();
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err_sticky got=%b want=1", err_illegal); end
  endtask

  task automatic test_flush();
    idleInputs();
    setReq0(1'b1, 3'b000, 32'd1, 32'd2);
    #1;
    checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("[TB] FAIL flush_first_ready got=%b want=1", req_ready_0); end
    stepCycle();
    setReq0(1'b0, 3'b000, 32'h0, 32'h0);
    setReq1(1'b1, 3'b000, 32'd3, 32'd4);
    flush = 1'b1;
    #1;
    checks++; if (req_ready_1 !== 1'b0 || req_ready_0 !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_grant got=%b%b want=00", req_ready_1, req_ready_0); end
    stepCycle();
    idleInputs();
    #1;
    checks++; if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL flush_resp_c2 got=%b%b want=00", resp_valid_1, resp_valid_0); end
    stepCycle();
    checks++; if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin errors++; $display("[TB] FAIL flush_resp_c3 got=%b%b want=00", resp_valid_1, resp_valid_0); end
    checks++; if (err_illegal !== 1'b1) begin errors++; $display("[TB] FAIL flush_keeps_err got=%b want=1", err_illegal); end
    setReq1(1'b1, 3'b000, 32'd3, 32'd4);
    #1;
    checks++; if (req_ready_1 !== 1'b1) begin errors++; $display("[TB] FAIL flush_recover_ready got=%b want=1", req_ready_1); end
    stepCycle();
    idleInputs();
    stepCycle();
    checks++; if (resp_valid_1 !== 1'b1 || resp_result !== 32'd7) begin errors++; $display("[TB] FAIL flush_recover_resp got=%b/%h want=1/00000007", resp_valid_1, resp_result); end
    stepCycle();
  endtask

  task automatic test_reset_mid();
    idleInputs();
    setReq0(1'b1, 3'b000, 32'd2, 32'd2);
    stepCycle();
    idleInputs();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (alu_ctr !== 3'b000 || alu_op1 !== 32'h0 || alu_op2 !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_alu got=%b/%h/%h want=000/0/0", alu_ctr, alu_op1, alu_op2); end
    checks++; if (err_illegal !== 1'b0 || resp_result !== 32'h0 || resp_zero !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outputs got=%b/%h/%b want=0/0/0", err_illegal, resp_result, resp_zero); end
    stepCycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin
        errors++; $display("[TB] FAIL rstmid_no_resp[%0d] got=%b%b want=00", i, resp_valid_1, resp_valid_0);
      end
      stepCycle();
    end
    setReq0(1'b1, 3'b000, 32'h0, 32'h0);
    setReq1(1'b1, 3'b000, 32'h0, 32'h0);
    #1;
    checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_first_tie got=%b%b want=01", req_ready_1, req_ready_0); end
    stepCycle();
    idleInputs();
  endtask

  initial begin
    reset = 1'b0;
    idleInputs();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
